// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage.
//   - alu_op_e : ALU operation select {S1,S0}
//   - cond_e   : ifun condition codes used by cnd evaluation
//   - cc_t     : condition-code register layout
//   - CcReset  : condition-code reset value (ZF=1, SF=0, OF=0, CF=0)
// Optional feature macro: ALU_RESULT_STAGE_CARRY_FLAG_EN adds a CF bit to cc_t.
package alu_result_stage_pkg;

    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpSub = 2'b01,
        OpAnd = 2'b10,
        OpXor = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        CondAlways = 4'd0,
        CondLe     = 4'd1,
        CondL      = 4'd2,
        CondE      = 4'd3,
        CondNe     = 4'd4,
        CondGe     = 4'd5,
        CondG      = 4'd6,
        CondB      = 4'd8,
        CondAe     = 4'd9
    } cond_e;

`ifdef ALU_RESULT_STAGE_CARRY_FLAG_EN
    typedef struct packed {
        logic cf;
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CcReset = '{cf: 1'b0, zf: 1'b1, sf: 1'b0, of: 1'b0};
`else
    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CcReset = '{zf: 1'b1, sf: 1'b0, of: 1'b0};
`endif

endpackage

// File: rtl/alu_result_stage_cond.sv
// cc_cond_eval: combinational branch/cmov condition evaluator.
// Ports:
//   ifun        in  condition function select (cond_e encoding)
//   zf, sf, of  in  condition-code flags
//   cf          in  carry flag (only with ALU_RESULT_STAGE_CARRY_FLAG_EN)
//   cnd         out condition outcome
// Optional feature macro: ALU_RESULT_STAGE_CARRY_FLAG_EN enables ifun 8 (b) and 9 (ae).
module cc_cond_eval
    import alu_result_stage_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
`ifdef ALU_RESULT_STAGE_CARRY_FLAG_EN
    input  logic       cf,
`endif
    output logic       cnd
);

    logic lt;

    // Signed "less than" from the last compare.
    assign lt = sf ^ of;

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            CondAlways: cnd = 1'b1;
            CondLe:     cnd = lt | zf;
            CondL:      cnd = lt;
            CondE:      cnd = zf;
            CondNe:     cnd = ~zf;
            CondGe:     cnd = ~lt;
            CondG:      cnd = ~lt & ~zf;
`ifdef ALU_RESULT_STAGE_CARRY_FLAG_EN
            CondB:      cnd = cf;
            CondAe:     cnd = ~cf;
`endif
            default:    cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: execute-stage back end behind the ALU.
// Registers valE, keeps the ZF/SF/OF condition-code register, evaluates cnd against the
// CC value held before the current transaction, and presents the result downstream over a
// valid/ready handshake with one cycle of latency and no bubbles when streaming.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    upstream handshake (in_ready is combinational)
//   alu_out                ALU result, bit DATA_W is carry/borrow
//   a_in, b_in, alu_op     operands and op select as seen by the ALU
//   set_cc                 update CC with this transaction's flags
//   ifun                   condition function for cnd
//   out_valid / out_ready  downstream handshake
//   val_e, cnd             registered result and condition
//   zf, sf, of (cf)        current CC register
//   op_count               saturating count of output handshakes
// Optional feature macro: ALU_RESULT_STAGE_CARRY_FLAG_EN adds the cf output and ifun 8/9.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W:0]   alu_out,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [1:0]        alu_op,
    input  logic              set_cc,
    input  logic [3:0]        ifun,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] val_e,
    output logic              cnd,
    output logic              zf,
    output logic              sf,
    output logic              of,
`ifdef ALU_RESULT_STAGE_CARRY_FLAG_EN
    output logic              cf,
`endif
    output logic [CNT_W-1:0]  op_count
);

    logic              out_valid_q;
    logic [DATA_W-1:0] val_e_q;
    logic              cnd_q;
    cc_t               cc_q;
    cc_t               cc_new;
    logic [CNT_W-1:0]  op_count_q;
    logic              accept;
    logic              fire;
    logic              cnd_next;
    logic [DATA_W-1:0] r;
    logic              a_msb;
    logic              b_msb;
    logic              r_msb;

    // Only the operand sign bits feed the overflow logic.
`ifdef ALU_RESULT_STAGE_CARRY_FLAG_EN
    logic unused_bits;
    assign unused_bits = ^{a_in[DATA_W-2:0], b_in[DATA_W-2:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{alu_out[DATA_W], a_in[DATA_W-2:0], b_in[DATA_W-2:0]};
`endif

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign fire     = out_valid_q & out_ready;

    assign r     = alu_out[DATA_W-1:0];
    assign a_msb = a_in[DATA_W-1];
    assign b_msb = b_in[DATA_W-1];
    assign r_msb = r[DATA_W-1];

    // Flags produced by the transaction currently on the inputs.
    always_comb begin
        cc_new    = CcReset;
        cc_new.zf = (r == '0);
        cc_new.sf = r_msb;
        cc_new.of = 1'b0;
        case (alu_op_e'(alu_op))
            OpAdd: begin
                cc_new.of = (a_msb == b_msb) && (r_msb != a_msb);
`ifdef ALU_RESULT_STAGE_CARRY_FLAG_EN
                cc_new.cf = alu_out[DATA_W];
`endif
            end
            OpSub: begin
                cc_new.of = (a_msb != b_msb) && (r_msb != a_msb);
`ifdef ALU_RESULT_STAGE_CARRY_FLAG_EN
                // ALU carry-out of A + ~B + 1 is high when there is no borrow.
                cc_new.cf = ~alu_out[DATA_W];
`endif
            end
            default: begin
                cc_new.of = 1'b0;
            end
        endcase
    end

    // Condition sees the CC before this transaction's own update.
    cc_cond_eval u_cond (
        .ifun (ifun),
        .zf   (cc_q.zf),
        .sf   (cc_q.sf),
        .of   (cc_q.of),
`ifdef ALU_RESULT_STAGE_CARRY_FLAG_EN
        .cf   (cc_q.cf),
`endif
        .cnd  (cnd_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            val_e_q     <= '0;
            cnd_q       <= 1'b0;
            cc_q        <= CcReset;
            op_count_q  <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                val_e_q     <= r;
                cnd_q       <= cnd_next;
                if (set_cc) begin
                    cc_q <= cc_new;
                end
            end else if (fire) begin
                out_valid_q <= 1'b0;
            end
            if (fire && (op_count_q != '1)) begin
                op_count_q <= op_count_q + CNT_W'(1);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign val_e     = val_e_q;
    assign cnd       = cnd_q;
    assign zf        = cc_q.zf;
    assign sf        = cc_q.sf;
    assign of        = cc_q.of;
`ifdef ALU_RESULT_STAGE_CARRY_FLAG_EN
    assign cf        = cc_q.cf;
`endif
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed vector table, hand-written
// backpressure/reset sequences, then randomized traffic against a reference model.
// Optional feature macro: ALU_RESULT_STAGE_CARRY_FLAG_EN.
module tb_alu_result_stage;

    localparam int unsigned DW   = 64;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = 15;
`ifdef ALU_RESULT_STAGE_CARRY_FLAG_EN
    localparam bit CF_EN = 1'b1;
`else
    localparam bit CF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW:0]   alu_out;
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;
    logic [1:0]    alu_op;
    logic          set_cc;
    logic [3:0]    ifun;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] val_e;
    logic          cnd;
    logic          zf;
    logic          sf;
    logic          of;
`ifdef ALU_RESULT_STAGE_CARRY_FLAG_EN
    logic          cf;
`endif
    logic [CW-1:0] op_count;

    always #5 clk = ~clk;

    alu_result_stage #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_out   (alu_out),
        .a_in      (a_in),
        .b_in      (b_in),
        .alu_op    (alu_op),
        .set_cc    (set_cc),
        .ifun      (ifun),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .val_e     (val_e),
        .cnd       (cnd),
        .zf        (zf),
        .sf        (sf),
        .of        (of),
`ifdef ALU_RESULT_STAGE_CARRY_FLAG_EN
        .cf        (cf),
`endif
        .op_count  (op_count)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit            m_valid;
    logic [DW-1:0] m_val;
    bit            m_cnd;
    bit            m_zf;
    bit            m_sf;
    bit            m_of;
    bit            m_cf;
    int            m_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_cond(input logic [3:0] f, input bit z, input bit s, input bit o,
                                    input bit c);
        bit lt;
        lt = s ^ o;
        case (f)
            4'd0:    return 1'b1;
            4'd1:    return lt || z;
            4'd2:    return lt;
            4'd3:    return z;
            4'd4:    return !z;
            4'd5:    return !lt;
            4'd6:    return !lt && !z;
            4'd8:    return CF_EN && c;
            4'd9:    return CF_EN && !c;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [DW:0] alu_model(input logic [1:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b, input bit junk);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} + {1'b0, ~b} + 65'd1;
            2'b10:   return {junk, a & b};
            default: return {junk, a ^ b};
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_val   = '0;
        m_cnd   = 1'b0;
        m_zf    = 1'b1;
        m_sf    = 1'b0;
        m_of    = 1'b0;
        m_cf    = 1'b0;
        m_count = 0;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        bit                ready;
        bit                fire;
        logic signed [DW:0] s;
        logic [DW:0]        u;
        if (rst) begin
            model_reset();
        end else begin
            ready = !m_valid || out_ready;
            fire  = m_valid && out_ready;
            if (fire && m_count < CMAX) m_count++;
            if (in_valid && ready) begin
                m_cnd   = ref_cond(ifun, m_zf, m_sf, m_of, m_cf);
                m_val   = alu_out[DW-1:0];
                m_valid = 1'b1;
                if (set_cc) begin
                    m_zf = (m_val == 0);
                    m_sf = m_val[DW-1];
                    m_of = 1'b0;
                    m_cf = 1'b0;
                    if (alu_op == 2'b00) begin
                        s    = $signed({a_in[DW-1], a_in}) + $signed({b_in[DW-1], b_in});
                        m_of = s[DW] ^ s[DW-1];
                        u    = {1'b0, a_in} + {1'b0, b_in};
                        m_cf = u[DW];
                    end else if (alu_op == 2'b01) begin
                        s    = $signed({a_in[DW-1], a_in}) - $signed({b_in[DW-1], b_in});
                        m_of = s[DW] ^ s[DW-1];
                        m_cf = (a_in < b_in);
                    end
                end
            end else if (fire) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic drive(input bit iv, input bit ordy, input logic [1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW:0] alu, input bit sc, input logic [3:0] f);
        in_valid  = iv;
        out_ready = ordy;
        alu_op    = op;
        a_in      = a;
        b_in      = b;
        alu_out   = alu;
        set_cc    = sc;
        ifun      = f;
    endtask

    // Called at a negedge with inputs driven; returns #1 after the next posedge.
    task automatic tick();
        #1;
        check("in_ready", in_ready, (!m_valid || out_ready));
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        check("out_valid", out_valid, m_valid);
        check("op_count", op_count, 64'(m_count));
        check("zf", zf, m_zf);
        check("sf", sf, m_sf);
        check("of", of, m_of);
`ifdef ALU_RESULT_STAGE_CARRY_FLAG_EN
        check("cf", cf, m_cf);
`endif
        if (m_valid) begin
            check("val_e", val_e, m_val);
            check("cnd", cnd, m_cnd);
        end
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW:0]   alu;
        bit            sc;
        logic [3:0]    f;
        logic [DW-1:0] e_val;
        bit            e_cnd;
        bit            e_zf;
        bit            e_sf;
        bit            e_of;
        int            e_cnt;
    } vec_t;

    vec_t vt[10];

    function automatic logic [DW-1:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        logic [1:0]    rop;

        vt[0] = '{2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 65'h0_8000_0000_0000_0000, 1, 4'd0,
                  64'h8000_0000_0000_0000, 1, 0, 1, 1, 0};
        vt[1] = '{2'b01, 64'd5, 64'd5, 65'h1_0000_0000_0000_0000, 1, 4'd2,
                  64'd0, 0, 1, 0, 0, 1};
        vt[2] = '{2'b10, 64'd0, 64'd0, 65'd0, 0, 4'd3, 64'd0, 1, 1, 0, 0, 2};
        vt[3] = '{2'b11, 64'd3, 64'd1, 65'd2, 0, 4'd4, 64'd2, 0, 1, 0, 0, 3};
        vt[4] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  65'h1_FFFF_FFFF_FFFF_FFFE, 1, 4'd1,
                  64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 1, 0, 4};
        vt[5] = '{2'b11, 64'hF0, 64'hF0, 65'd0, 0, 4'd2, 64'd0, 1, 0, 1, 0, 5};
        vt[6] = '{2'b10, 64'hFF, 64'h0F, 65'h0F, 0, 4'd5, 64'h0F, 0, 0, 1, 0, 6};
        vt[7] = '{2'b10, 64'd1, 64'd1, 65'd1, 0, 4'd6, 64'd1, 0, 0, 1, 0, 7};
        vt[8] = '{2'b00, 64'd1, 64'd2, 65'd3, 0, 4'd7, 64'd3, 0, 0, 1, 0, 8};
        vt[9] = '{2'b01, 64'd2, 64'd3, 65'h0_FFFF_FFFF_FFFF_FFFF, 1, 4'd12,
                  64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 0, 9};

        // Reset
        rst = 1'b1;
        drive(0, 0, 2'b00, '0, '0, '0, 0, 4'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_zf", zf, 1);
        check("rst_sf", sf, 0);
        check("rst_of", of, 0);
        check("rst_op_count", op_count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_val_e", val_e, 0);
        check("rst_cnd", cnd, 0);
        rst = 1'b0;

        // Directed vectors, streaming with out_ready high
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, vt[i].op, vt[i].a, vt[i].b, vt[i].alu, vt[i].sc, vt[i].f);
            tick();
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_val_e", i), val_e, vt[i].e_val);
            check($sformatf("vec%0d_cnd", i), cnd, vt[i].e_cnd);
            check($sformatf("vec%0d_zf", i), zf, vt[i].e_zf);
            check($sformatf("vec%0d_sf", i), sf, vt[i].e_sf);
            check($sformatf("vec%0d_of", i), of, vt[i].e_of);
            check($sformatf("vec%0d_cnt", i), op_count, 64'(vt[i].e_cnt));
            @(negedge clk);
        end

        // Backpressure: result held, no accept, no count
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 2'b00, 64'd10, 64'd20, 65'd30, 0, 4'd0);
            tick();
            check("bp_in_ready", in_ready, 0);
            check("bp_val_e", val_e, 64'hFFFF_FFFF_FFFF_FFFF);
            check("bp_valid", out_valid, 1);
            check("bp_cnt", op_count, 9);
            @(negedge clk);
        end

        // Release: one result per cycle, no bubble
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 2'b00, 64'(100 + i), 64'd1, 65'(101 + i), 0, 4'd0);
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_val_e", val_e, 64'(101 + i));
            check("stream_cnt", op_count, 64'(10 + i));
            @(negedge clk);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            ra  = rnd_word();
            rb  = ($urandom_range(0, 3) == 0) ? ra : rnd_word();
            rop = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, rop, ra, rb,
                  alu_model(rop, ra, rb, 1'($urandom_range(0, 1))),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            tick();
            check_model();
            @(negedge clk);
        end
        rst = 1'b0;

        // Reset while a result is held under backpressure
        drive(1, 1, 2'b10, 64'h55, 64'h0F, 65'h05, 0, 4'd0);
        tick();
        check_model();
        @(negedge clk);
        drive(0, 0, 2'b00, '0, '0, '0, 0, 4'd0);
        tick();
        check("hold_valid", out_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_cnt", op_count, 0);
        check("mid_rst_zf", zf, 1);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, 2'b00, '0, '0, '0, 0, 4'd0);
        tick();
        check("post_rst_valid", out_valid, 0);
        check("post_rst_cnt", op_count, 0);
        @(negedge clk);

`ifdef ALU_RESULT_STAGE_CARRY_FLAG_EN
        drive(1, 1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65'h1_0000_0000_0000_0000, 1, 4'd0);
        tick();
        check("carry_cf", cf, 1);
        check("carry_zf", zf, 1);
        @(negedge clk);
        drive(1, 1, 2'b00, 64'd1, 64'd1, 65'd2, 0, 4'd8);
        tick();
        check("carry_b", cnd, 1);
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
